spi_adc_responder: RTL and testbench
====================================

SPI_ADC_RESPONDER -- requirements
Module: spi_adc_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on spi_sck/spi_cs_n/spi_mosi (legal 2..3).
REQ-002 SHALL have parameter MISO_IDLE, default 1'b0, meaning the spi_miso level whenever no bit is being driven.
REQ-003 CLK  input  1  system clock; all logic on rising edge.
REQ-004 global_safe_rst  input  1  asynchronous, active-high reset.
REQ-005 spi_sck  input  1  SPI clock from the initiator, mode 0 (idle low), asynchronous to CLK.
REQ-006 spi_cs_n  input  1  chip select, active low, asynchronous.
REQ-007 spi_mosi  input  1  command bits from the initiator.
REQ-008 spi_miso  output  1  conversion result to the initiator.
REQ-009 ch0_value  input  12  emulated channel-0 sample (e.g. accelerator pot).
REQ-010 ch1_value  input  12  emulated channel-1 sample (e.g. CdS cell).
REQ-011 conv_done  output  1  one-CLK pulse when a frame completes.
REQ-012 conv_ch  output  1  ODD bit of the last accepted command.
REQ-013 frame_err  output  1  one-CLK pulse on a frame aborted by spi_cs_n rising.

Function
REQ-014 SHALL synchronize all three SPI inputs through SYNC_STAGES flops and derive sck_rise/sck_fall/cs_fall/cs_rise pulses by edge detection of the synchronized signals; SCK frequency SHALL be at most CLK/8.
REQ-015 SHALL implement FSM states IDLE, WAIT_START, CMD, NULLB, DATA_MSB, DATA_LSB, DONE.
REQ-016 IDLE -> WAIT_START on cs_fall; every state -> IDLE when synchronized spi_cs_n is high.
REQ-017 WAIT_START: on sck_rise with mosi=0 stay (leading zeros ignored); with mosi=1 -> CMD.
REQ-018 CMD: capture SGL, ODD, MSBF on the next 3 sck_rise events, in that order; after MSBF -> NULLB.
REQ-019 Sample latch: on the sck_rise capturing MSBF, latch result: SGL=1: ODD ? ch1_value : ch0_value; SGL=0, ODD=0: ch0-ch1, clipped to 0 if negative; SGL=0, ODD=1: ch1-ch0, clipped to 0; 13-bit signed intermediate, 12-bit unsigned result.
REQ-020 NULLB: on next sck_fall drive spi_miso=0 -> DATA_MSB.
REQ-021 DATA_MSB: on each of the next 12 sck_fall drive B11..B0; after B0: MSBF=1 -> DONE, MSBF=0 -> DATA_LSB.
REQ-022 DATA_LSB: on each of the next 11 sck_fall drive B1..B11 (B0 shared); after B11 -> DONE.
REQ-023 conv_done SHALL pulse exactly one CLK in the cycle the FSM enters DONE; conv_ch updates in that same cycle.
REQ-024 DONE: spi_miso=MISO_IDLE; further SCK edges ignored until spi_cs_n high.
REQ-025 spi_miso SHALL change no later than SYNC_STAGES+2 CLK cycles after the physical SCK falling edge, and never on sck_rise.
REQ-026 frame_err SHALL pulse one CLK when cs_rise occurs in CMD, NULLB, DATA_MSB or DATA_LSB; no pulse from IDLE, WAIT_START or DONE.
REQ-027 Simultaneous cs_rise and SCK edge in the same CLK: cs_rise wins, edge ignored.
REQ-028 ch0_value/ch1_value changes after the latch point SHALL NOT affect the frame in progress.
REQ-029 spi_miso SHALL equal MISO_IDLE in IDLE, WAIT_START, CMD and DONE.

Reset
REQ-030 On global_safe_rst: FSM=IDLE, bit counter=0, latched sample=0, spi_miso=MISO_IDLE, conv_done=0, conv_ch=0, frame_err=0, synchronizer flops=idle levels (sck 0, cs_n 1, mosi 0).
REQ-031 Reset asserted mid-frame SHALL abort without a frame_err pulse; after release a new frame requires a fresh cs_fall.

Structure
REQ-032 FSM state encoding, command bit positions and frame length constants (12 data bits, 3 command bits) SHALL live in the shared car-simulator package.
REQ-033 Synchronizer plus edge detect SHALL be one sub-module, spi_edge_sync, instantiated once for all three inputs.

Verification
REQ-034 ch0=0x0A5, frame 0,1,1,0,1 (zero, start, SGL=1, ODD=0, MSBF=1) -> MISO null 0 then 0000_1010_0101, conv_done one pulse, conv_ch=0.
REQ-035 ch1=0xFFF, SGL=1, ODD=1, MSBF=0 -> MSB-first 0xFFF then 11 LSB-first ones, conv_done after 27th falling edge, conv_ch=1.
REQ-036 ch0=0x100, ch1=0x300, SGL=0, ODD=0 -> data 0x000; ODD=1 -> data 0x200.
REQ-037 spi_cs_n raised after 5 data bits -> frame_err one pulse, no conv_done, spi_miso=MISO_IDLE, next frame returns correct value.
REQ-038 ch0 changed from 0x123 to 0x456 during DATA_MSB -> full frame still returns 0x123.
REQ-039 global_safe_rst pulsed during DATA_MSB -> all outputs at reset values, no frame_err, subsequent frame correct.

Source files
------------

// File: rtl/spi_adc_responder_pkg.sv
// Shared constants, FSM encoding and conversion math for the emulated SPI ADC.
package spi_adc_responder_pkg;
  localparam int DATA_BITS = 12;
  localparam int CMD_BITS  = 3;
  localparam int CMD_SGL   = 2;
  localparam int CMD_ODD   = 1;
  localparam int CMD_MSBF  = 0;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_START = 3'd1;
  localparam logic [2:0] ST_CMD        = 3'd2;
  localparam logic [2:0] ST_NULLB      = 3'd3;
  localparam logic [2:0] ST_DATA_MSB   = 3'd4;
  localparam logic [2:0] ST_DATA_LSB   = 3'd5;
  localparam logic [2:0] ST_DONE       = 3'd6;

  typedef logic [DATA_BITS-1:0] sample_t;

  typedef struct packed {
    logic sck_rise;
    logic sck_fall;
    logic cs_rise;
    logic cs_fall;
  } spi_edges_t;

  // Differential modes subtract in DATA_BITS+1 bits; the top bit is the borrow.
  function automatic sample_t adc_result(input logic sgl, input logic odd,
                                         input sample_t ch0, input sample_t ch1);
    logic [DATA_BITS:0] diff;
    diff = odd ? ({1'b0, ch1} - {1'b0, ch0}) : ({1'b0, ch0} - {1'b0, ch1});
    if (sgl) return odd ? ch1 : ch0;
    return diff[DATA_BITS] ? '0 : diff[DATA_BITS-1:0];
  endfunction
endpackage

// File: rtl/spi_adc_responder_if.sv
// SPI pins between the initiator (master) and the emulated ADC (slave).
interface spi_adc_responder_if;
  logic spi_sck;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_sck, spi_cs_n, spi_mosi, input spi_miso);
  modport slave  (input spi_sck, spi_cs_n, spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_adc_responder_edge_sync.sv
// Synchronizes sck/cs_n/mosi into CLK and derives single-cycle edge pulses.
module spi_edge_sync
  import spi_adc_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       global_safe_rst,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       cs_n_s,
  output logic       mosi_s,
  output spi_edges_t edges
);
  localparam logic [2:0] IDLE_LVL = 3'b010; // {mosi, cs_n, sck}

  logic [SYNC_STAGES-1:0][2:0] sync;
  logic [2:0]                  prev;
  logic [2:0]                  cur;
  logic [SYNC_STAGES:0]        vld_pipe;
  logic                        vld;

  assign cur = sync[SYNC_STAGES-1];
  assign vld = vld_pipe[SYNC_STAGES];

  always_ff @(posedge CLK or posedge global_safe_rst) begin
    if (global_safe_rst) begin
      sync     <= {SYNC_STAGES{IDLE_LVL}};
      prev     <= IDLE_LVL;
      vld_pipe <= '0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], {mosi, cs_n, sck}};
      prev     <= cur;
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are suppressed until the reset idle levels have been flushed out,
  // so a chip select already low at reset release never looks like a new frame.
  always_comb begin
    edges          = '0;
    edges.sck_rise = vld &  cur[0] & ~prev[0];
    edges.sck_fall = vld & ~cur[0] &  prev[0];
    edges.cs_rise  = vld &  cur[1] & ~prev[1];
    edges.cs_fall  = vld & ~cur[1] &  prev[1];
  end

  assign cs_n_s = cur[1];
  assign mosi_s = cur[2];
endmodule

// File: rtl/spi_adc_responder.sv
// Emulated 2-channel 12-bit SPI ADC: start bit, SGL/ODD/MSBF command, null bit,
// MSB-first data, optional LSB-first repeat.
module spi_adc_responder
  import spi_adc_responder_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic MISO_IDLE   = 1'b0
) (
  input  logic                     CLK,
  input  logic                     global_safe_rst,
  spi_adc_responder_if.slave       spi,
  input  sample_t                  ch0_value,
  input  sample_t                  ch1_value,
  output logic                     conv_done,
  output logic                     conv_ch,
  output logic                     frame_err
);
  localparam logic [3:0] CMD_LAST  = 4'(CMD_BITS - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);

  logic                cs_n_s;
  logic                mosi_s;
  spi_edges_t          edges;
  logic [2:0]          state;
  logic [3:0]          bit_cnt;
  logic [CMD_BITS-1:0] cmd;
  logic [CMD_BITS-1:0] cmd_next;
  sample_t             sample;
  logic                miso;
  logic                in_frame;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK             (CLK),
    .global_safe_rst (global_safe_rst),
    .sck             (spi.spi_sck),
    .cs_n            (spi.spi_cs_n),
    .mosi            (spi.spi_mosi),
    .cs_n_s          (cs_n_s),
    .mosi_s          (mosi_s),
    .edges           (edges)
  );

  assign spi.spi_miso = miso;
  assign cmd_next     = {cmd[CMD_BITS-2:0], mosi_s};
  assign in_frame     = (state == ST_CMD) || (state == ST_NULLB) ||
                        (state == ST_DATA_MSB) || (state == ST_DATA_LSB);

  always_ff @(posedge CLK or posedge global_safe_rst) begin
    if (global_safe_rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      cmd       <= '0;
      sample    <= '0;
      miso      <= MISO_IDLE;
      conv_done <= 1'b0;
      conv_ch   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      frame_err <= 1'b0;
      // A deselected bus overrides everything, including an SCK edge seen in
      // the same cycle as the chip-select rise.
      if (cs_n_s) begin
        state     <= ST_IDLE;
        bit_cnt   <= '0;
        miso      <= MISO_IDLE;
        frame_err <= edges.cs_rise & in_frame;
      end else begin
        case (state)
          ST_IDLE:
            if (edges.cs_fall) state <= ST_WAIT_START;
          ST_WAIT_START:
            if (edges.sck_rise && mosi_s) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
            end
          ST_CMD:
            if (edges.sck_rise) begin
              cmd     <= cmd_next;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == CMD_LAST) begin
                sample <= adc_result(cmd_next[CMD_SGL], cmd_next[CMD_ODD],
                                     ch0_value, ch1_value);
                state  <= ST_NULLB;
              end
            end
          ST_NULLB:
            if (edges.sck_fall) begin
              miso    <= 1'b0;
              bit_cnt <= DATA_LAST;
              state   <= ST_DATA_MSB;
            end
          ST_DATA_MSB:
            if (edges.sck_fall) begin
              miso <= sample[bit_cnt];
              if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - 4'd1;
              end else if (cmd[CMD_MSBF]) begin
                state     <= ST_DONE;
                conv_done <= 1'b1;
                conv_ch   <= cmd[CMD_ODD];
              end else begin
                bit_cnt <= 4'd1;
                state   <= ST_DATA_LSB;
              end
            end
          ST_DATA_LSB:
            if (edges.sck_fall) begin
              miso <= sample[bit_cnt];
              if (bit_cnt == DATA_LAST) begin
                state     <= ST_DONE;
                conv_done <= 1'b1;
                conv_ch   <= cmd[CMD_ODD];
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          // The final bit stays valid for the initiator's next rising edge,
          // then the line parks at its idle level.
          ST_DONE:
            if (edges.sck_fall) miso <= MISO_IDLE;
          default:
            state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: table vectors, random frames against a model,
// and hand-written abort / hold / reset sequences.
module tb_spi_adc_responder;
  import spi_adc_responder_pkg::*;

  localparam logic MISO_IDLE = 1'b0;
  localparam int   HALF      = 8;

  logic        CLK = 1'b0;
  logic        global_safe_rst = 1'b1;
  logic [11:0] ch0_value = '0;
  logic [11:0] ch1_value = '0;
  logic        conv_done, conv_ch, frame_err;

  spi_adc_responder_if spi_bus();

  spi_adc_responder #(.SYNC_STAGES(2), .MISO_IDLE(MISO_IDLE)) dut (
    .CLK             (CLK),
    .global_safe_rst (global_safe_rst),
    .spi             (spi_bus),
    .ch0_value       (ch0_value),
    .ch1_value       (ch1_value),
    .conv_done       (conv_done),
    .conv_ch         (conv_ch),
    .frame_err       (frame_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_fall = -1;
  int done_ch = -1;
  int nfall = 0;
  int rise_no = 0;
  int done_base, err_base;
  int g_lead;
  bit g_sgl, g_odd, g_msbf;
  bit rx [0:63];

  always @(negedge CLK) begin
    if (conv_done) begin
      done_cnt++;
      done_fall = nfall;
      done_ch = int'(conv_ch);
    end
    if (frame_err) err_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic [11:0] c0, input logic [11:0] c1,
                                        input bit sgl, input bit odd);
    int d;
    if (sgl) return odd ? c1 : c0;
    d = odd ? (int'(c1) - int'(c0)) : (int'(c0) - int'(c1));
    return (d < 0) ? 12'd0 : 12'(d);
  endfunction

  function automatic bit tx_bit(input int r);
    if (r <= g_lead) return 1'b0;
    if (r == g_lead + 1) return 1'b1;
    if (r == g_lead + 2) return g_sgl;
    if (r == g_lead + 3) return g_odd;
    if (r == g_lead + 4) return g_msbf;
    return 1'($urandom);
  endfunction

  task automatic sck_cycle();
    rise_no++;
    spi_bus.spi_mosi = tx_bit(rise_no);
    repeat (HALF) @(negedge CLK);
    rx[rise_no] = spi_bus.spi_miso;
    spi_bus.spi_sck = 1'b1;
    repeat (HALF) @(negedge CLK);
    spi_bus.spi_sck = 1'b0;
    nfall++;
  endtask

  task automatic start_frame(input int lead, input bit sgl, input bit odd, input bit msbf);
    g_lead = lead; g_sgl = sgl; g_odd = odd; g_msbf = msbf;
    rise_no = 0; nfall = 0;
    done_base = done_cnt; err_base = err_cnt;
    spi_bus.spi_cs_n = 1'b0;
    repeat (HALF) @(negedge CLK);
  endtask

  task automatic clock_to(input int n);
    while (rise_no < n) sck_cycle();
  endtask

  task automatic end_frame();
    repeat (HALF) @(negedge CLK);
    spi_bus.spi_cs_n = 1'b1;
    spi_bus.spi_mosi = 1'b0;
    repeat (4 * HALF) @(negedge CLK);
  endtask

  function automatic int last_rise();
    return g_lead + (g_msbf ? 17 : 28);
  endfunction

  task automatic check_frame(input string name, input logic [11:0] exp);
    logic [11:0] msbw, lsbw;
    msbw = '0;
    for (int i = 0; i < 12; i++) msbw = {msbw[10:0], rx[g_lead + 6 + i]};
    lsbw = '0;
    lsbw[0] = msbw[0];
    for (int i = 1; i < 12; i++) lsbw[i] = rx[g_lead + 17 + i];
    check({name, " null"}, int'(rx[g_lead + 5]), 0);
    check({name, " msb_data"}, int'(msbw), int'(exp));
    if (!g_msbf) check({name, " lsb_data"}, int'(lsbw), int'(exp));
    check({name, " done_pulses"}, done_cnt - done_base, 1);
    check({name, " done_fall"}, done_fall, g_lead + (g_msbf ? 16 : 27));
    check({name, " conv_ch"}, done_ch, int'(g_odd));
    check({name, " frame_err"}, err_cnt - err_base, 0);
    check({name, " idle_tail"}, int'(rx[last_rise() + 1]), int'(MISO_IDLE));
  endtask

  task automatic run_full(input string name, input int lead, input bit sgl, input bit odd,
                          input bit msbf, input logic [11:0] exp);
    start_frame(lead, sgl, odd, msbf);
    clock_to(last_rise() + 1);
    end_frame();
    check_frame(name, exp);
  endtask

  typedef struct {
    logic [11:0] ch0;
    logic [11:0] ch1;
    bit          sgl;
    bit          odd;
    bit          msbf;
    int          lead;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [11:0] part;
    vecs[0] = '{12'h0A5, 12'h7FF, 1, 0, 1, 1, 12'h0A5};
    vecs[1] = '{12'h123, 12'hFFF, 1, 1, 0, 0, 12'hFFF};
    vecs[2] = '{12'h100, 12'h300, 0, 0, 1, 0, 12'h000};
    vecs[3] = '{12'h100, 12'h300, 0, 1, 1, 0, 12'h200};
    vecs[4] = '{12'h800, 12'h7FF, 0, 0, 0, 2, 12'h001};
    vecs[5] = '{12'hFFF, 12'h000, 0, 1, 1, 0, 12'h000};

    spi_bus.spi_sck = 1'b0;
    spi_bus.spi_cs_n = 1'b1;
    spi_bus.spi_mosi = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst miso", int'(spi_bus.spi_miso), int'(MISO_IDLE));
    check("rst conv_done", int'(conv_done), 0);
    check("rst conv_ch", int'(conv_ch), 0);
    check("rst frame_err", int'(frame_err), 0);
    global_safe_rst = 1'b0;
    repeat (6) @(negedge CLK);

    foreach (vecs[i]) begin
      ch0_value = vecs[i].ch0;
      ch1_value = vecs[i].ch1;
      run_full($sformatf("vec%0d", i), vecs[i].lead, vecs[i].sgl, vecs[i].odd,
               vecs[i].msbf, vecs[i].exp);
    end

    for (int i = 0; i < 8; i++) begin
      bit s, o, m;
      ch0_value = 12'($urandom);
      ch1_value = 12'($urandom);
      s = 1'($urandom); o = 1'($urandom); m = 1'($urandom);
      run_full($sformatf("rand%0d", i), int'($urandom_range(0, 3)), s, o, m,
               model(ch0_value, ch1_value, s, o));
    end

    // chip select pulled after five data bits
    ch0_value = 12'h5A5;
    start_frame(0, 1, 0, 1);
    clock_to(10);
    part = '0;
    for (int i = 6; i <= 10; i++) part = {part[10:0], rx[i]};
    end_frame();
    check("abort bits", int'(part), int'(12'h5A5 >> 7));
    check("abort frame_err", err_cnt - err_base, 1);
    check("abort no_done", done_cnt - done_base, 0);
    check("abort miso", int'(spi_bus.spi_miso), int'(MISO_IDLE));
    run_full("abort_next", 0, 1, 0, 1, 12'h5A5);

    // channel value changes after the latch point
    ch1_value = 12'h123;
    start_frame(1, 1, 1, 1);
    clock_to(9);
    ch1_value = 12'h456;
    clock_to(last_rise() + 1);
    end_frame();
    check_frame("ch_hold", 12'h123);

    // reset in the middle of the data phase
    ch1_value = 12'h3C3;
    start_frame(0, 1, 1, 1);
    clock_to(9);
    global_safe_rst = 1'b1;
    #1;
    check("midrst miso", int'(spi_bus.spi_miso), int'(MISO_IDLE));
    check("midrst conv_done", int'(conv_done), 0);
    check("midrst conv_ch", int'(conv_ch), 0);
    check("midrst frame_err", int'(frame_err), 0);
    repeat (3) @(negedge CLK);
    global_safe_rst = 1'b0;
    clock_to(12);
    end_frame();
    check("midrst no_err", err_cnt - err_base, 0);
    check("midrst no_done", done_cnt - done_base, 0);
    run_full("rst_next", 0, 1, 1, 1, 12'h3C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
